// File: rtl/acc_cpu_pkg.sv
// Shared opcode encoding, FSM state type and opcode classification helpers
// for the multi-cycle accumulator core.
package acc_cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA  = 4'h1;
    localparam logic [OPC_W-1:0] OP_STA  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h8;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h9;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'hA;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'hB;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JN   = 4'hD;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_DMEM  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Opcodes LDA..XOR need a data-bus access before they can complete
    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op >= OP_LDA) && (op <= OP_XOR);
    endfunction

    // Opcodes whose completion writes the accumulator (and hence Z/N)
    function automatic logic writes_acc(input logic [OPC_W-1:0] op);
        return (op != OP_NOP) && (op != OP_STA) && (op < OP_JMP);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: b is either memory data or the immediate,
// c_we marks the opcodes that own the carry flag.
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [OPC_W-1:0] op,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic             c_in,
    output logic [DW-1:0]    result,
    output logic             c_out,
    output logic             c_we
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    // Extra top bit is carry-out for add and borrow for subtract
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = a;
        c_out  = c_in;
        c_we   = 1'b0;
        case (op)
            OP_LDA, OP_LDI: result = b;
            OP_ADD, OP_ADDI: begin
                result = w_sum[DW-1:0];
                c_out  = w_sum[DW];
                c_we   = 1'b1;
            end
            OP_SUB: begin
                result = w_diff[DW-1:0];
                c_out  = w_diff[DW];
                c_we   = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                c_out  = a[DW-1];
                c_we   = 1'b1;
            end
            OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                c_out  = a[0];
                c_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator core with Harvard req/ack instruction and data
// buses; FETCH -> EXEC [-> DMEM] per instruction, HLT parks in HALT.
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 8,
    parameter int unsigned OPW = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              i_req,
    output logic [AW-1:0]     i_addr,
    input  logic [OPW+AW-1:0] i_rdata,
    input  logic              i_ack,
    output logic              d_req,
    output logic              d_we,
    output logic [AW-1:0]     d_addr,
    output logic [DW-1:0]     d_wdata,
    input  logic [DW-1:0]     d_rdata,
    input  logic              d_ack,
    output logic [DW-1:0]     acc_out,
    output logic [AW-1:0]     pc_out,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              halted,
    output logic              retire
);

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_pc, w_pc_nxt;
    logic [DW-1:0]       r_acc, w_acc_nxt;
    logic                r_z, w_z_nxt;
    logic                r_n, w_n_nxt;
    logic                r_c, w_c_nxt;
    logic [OPW+AW-1:0]   r_ir, w_ir_nxt;
    logic                r_retire, w_retire_nxt;

    logic [OPC_W-1:0]    w_op;
    logic [AW-1:0]       w_operand;
    logic [DW-1:0]       w_imm;
    logic [DW-1:0]       w_alu_b;
    logic [DW-1:0]       w_alu_res;
    logic                w_alu_c;
    logic                w_alu_cwe;
    logic                w_commit;

    assign w_op      = r_ir[AW +: OPC_W];
    assign w_operand = r_ir[AW-1:0];
    assign w_imm     = DW'(w_operand);
    assign w_alu_b   = (r_state == S_DMEM) ? d_rdata : w_imm;

    acc_alu #(
        .DW (DW)
    ) u_alu (
        .op     (w_op),
        .a      (r_acc),
        .b      (w_alu_b),
        .c_in   (r_c),
        .result (w_alu_res),
        .c_out  (w_alu_c),
        .c_we   (w_alu_cwe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_acc    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_ir     <= '0;
            r_retire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_acc    <= w_acc_nxt;
            r_z      <= w_z_nxt;
            r_n      <= w_n_nxt;
            r_c      <= w_c_nxt;
            r_ir     <= w_ir_nxt;
            r_retire <= w_retire_nxt;
        end
    end

    // Next-state, PC sequencing and result commit; branches read pre-EXEC flags
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_acc_nxt    = r_acc;
        w_z_nxt      = r_z;
        w_n_nxt      = r_n;
        w_c_nxt      = r_c;
        w_ir_nxt     = r_ir;
        w_retire_nxt = 1'b0;
        w_commit     = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (i_ack) begin
                    w_ir_nxt    = i_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem_op(w_op)) begin
                    w_state_nxt = S_DMEM;
                end else if (w_op == OP_HLT) begin
                    w_state_nxt  = S_HALT;
                    w_retire_nxt = 1'b1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_FETCH;
                    if ((w_op == OP_JMP) || ((w_op == OP_JN) && r_n) ||
                        ((w_op == OP_JZ) && r_z)) begin
                        w_pc_nxt = w_operand;
                    end else begin
                        w_pc_nxt = r_pc + AW'(1);
                    end
                end
            end
            S_DMEM: begin
                if (d_ack) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = r_pc + AW'(1);
                end
            end
            default: ;
        endcase

        if (w_commit) begin
            w_retire_nxt = 1'b1;
            if (writes_acc(w_op)) begin
                w_acc_nxt = w_alu_res;
                w_z_nxt   = (w_alu_res == '0);
                w_n_nxt   = w_alu_res[DW-1];
            end
            if (w_alu_cwe) begin
                w_c_nxt = w_alu_c;
            end
        end
    end

    // Requests decode the state register and are forced low while in reset
    assign i_req   = reset && (r_state == S_FETCH);
    assign i_addr  = r_pc;
    assign d_req   = reset && (r_state == S_DMEM);
    assign d_we    = (r_state == S_DMEM) && (w_op == OP_STA);
    assign d_addr  = w_operand;
    assign d_wdata = r_acc;

    assign acc_out = r_acc;
    assign pc_out  = r_pc;
    assign flag_z  = r_z;
    assign flag_n  = r_n;
    assign flag_c  = r_c;
    assign halted  = (r_state == S_HALT);
    assign retire  = r_retire;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: bus models with wait states, an instruction-level
// reference model feeding a retire scoreboard, and a write-check queue.
module tb_acc_cpu_mc;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned OPW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [OPW+AW-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;
    logic [DW-1:0]     acc_out;
    logic [AW-1:0]     pc_out;
    logic              flag_z, flag_n, flag_c;
    logic              halted;
    logic              retire;

    always #5 clk = ~clk;

    acc_cpu_mc #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .acc_out(acc_out), .pc_out(pc_out),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .halted(halted), .retire(retire)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] acc;
        logic       z, n, c;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    exp_t       sb[$];
    wr_t        wq[$];
    logic [11:0] imem [256];
    logic [7:0]  dmem [256];
    logic [7:0]  m_dmem [256];
    logic [7:0]  m_pc, m_acc;
    logic        m_z, m_n, m_c;
    logic [7:0]  i_addr_q, d_addr_q;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_last = 0;
    int          i_cnt, d_cnt, i_wait, d_wait;
    bit          stray, first_fetch;

    // Reference model: architectural effect of one fetched instruction
    task automatic exec_model(input logic [11:0] w);
        logic [3:0] op;
        logic [7:0] opd, mv;
        logic [8:0] t;
        logic       zb, nb, wa;
        exp_t       e;
        wr_t        wr;
        op = w[11:8]; opd = w[7:0]; mv = m_dmem[opd];
        zb = m_z; nb = m_n; wa = 1'b0;
        e.lat = i_wait + 2;
        case (op)
            4'h1: begin m_acc = mv; wa = 1'b1; end
            4'h2: begin m_dmem[opd] = m_acc; wr.addr = opd; wr.data = m_acc; wq.push_back(wr); end
            4'h3: begin t = {1'b0, m_acc} + {1'b0, mv}; m_acc = t[7:0]; m_c = t[8]; wa = 1'b1; end
            4'h4: begin m_c = (m_acc < mv); m_acc = m_acc - mv; wa = 1'b1; end
            4'h5: begin m_acc = m_acc & mv; wa = 1'b1; end
            4'h6: begin m_acc = m_acc | mv; wa = 1'b1; end
            4'h7: begin m_acc = m_acc ^ mv; wa = 1'b1; end
            4'h8: begin m_acc = opd; wa = 1'b1; end
            4'h9: begin t = {1'b0, m_acc} + {1'b0, opd}; m_acc = t[7:0]; m_c = t[8]; wa = 1'b1; end
            4'hA: begin m_c = m_acc[7]; m_acc = {m_acc[6:0], 1'b0}; wa = 1'b1; end
            4'hB: begin m_c = m_acc[0]; m_acc = {1'b0, m_acc[7:1]}; wa = 1'b1; end
            default: ;
        endcase
        if (op >= 4'h1 && op <= 4'h7) e.lat += d_wait + 1;
        if (wa) begin m_z = (m_acc == 8'h00); m_n = m_acc[7]; end
        if (op == 4'hF) begin
        end else if (op == 4'hC || (op == 4'hD && nb) || (op == 4'hE && zb)) begin
            m_pc = opd;
        end else begin
            m_pc = m_pc + 8'd1;
        end
        e.pc = m_pc; e.acc = m_acc; e.z = m_z; e.n = m_n; e.c = m_c;
        sb.push_back(e);
    endtask

    // One clock: sample outputs on the falling edge, drive acks for this cycle
    task automatic step();
        exp_t e;
        wr_t  w;
        @(negedge clk);
        cyc++;
        if (first_fetch && i_req === 1'b1) begin t_last = cyc; first_fetch = 1'b0; end
        if (retire === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected cyc=%0d pc=%h", cyc, pc_out);
            end else begin
                e = sb.pop_front();
                if (pc_out !== e.pc || acc_out !== e.acc ||
                    {flag_z, flag_n, flag_c} !== {e.z, e.n, e.c} || (cyc - t_last) != e.lat) begin
                    errors++;
                    $display("FAIL retire_state got pc=%h acc=%h znc=%b%b%b lat=%0d want pc=%h acc=%h znc=%b%b%b lat=%0d",
                             pc_out, acc_out, flag_z, flag_n, flag_c, cyc - t_last,
                             e.pc, e.acc, e.z, e.n, e.c, e.lat);
                end
                t_last = cyc;
            end
        end
        i_ack = 1'b0;
        d_ack = 1'b0;
        if (i_req === 1'b1) begin
            if (i_cnt > 0) begin
                checks++;
                if (i_addr !== i_addr_q) begin
                    errors++;
                    $display("FAIL i_addr_stable got %h want %h", i_addr, i_addr_q);
                end
            end
            i_addr_q = i_addr;
            if (i_cnt == i_wait) begin
                i_ack = 1'b1; i_rdata = imem[i_addr]; i_cnt = 0;
                exec_model(imem[i_addr]);
            end else begin
                i_cnt++; i_rdata = 12'($urandom);
            end
        end else begin
            i_cnt = 0; i_rdata = 12'($urandom);
            if (stray) i_ack = 1'($urandom_range(0, 1));
        end
        if (d_req === 1'b1) begin
            if (d_cnt > 0) begin
                checks++;
                if (d_addr !== d_addr_q) begin
                    errors++;
                    $display("FAIL d_addr_stable got %h want %h", d_addr, d_addr_q);
                end
            end
            d_addr_q = d_addr;
            if (d_cnt == d_wait) begin
                d_ack = 1'b1; d_cnt = 0;
                if (d_we === 1'b1) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected addr=%h data=%h", d_addr, d_wdata);
                    end else begin
                        w = wq.pop_front();
                        if (d_addr !== w.addr || d_wdata !== w.data) begin
                            errors++;
                            $display("FAIL write_data got %h@%h want %h@%h", d_wdata, d_addr, w.data, w.addr);
                        end
                    end
                    dmem[d_addr] = d_wdata;
                end else begin
                    d_rdata = dmem[d_addr];
                end
            end else begin
                d_cnt++; d_rdata = 8'($urandom);
            end
        end else begin
            d_cnt = 0; d_rdata = 8'($urandom);
            if (stray) d_ack = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic put(input int a, input logic [3:0] op, input logic [7:0] opd);
        imem[a] = {op, opd};
    endtask

    task automatic clear_mem();
        foreach (imem[i]) imem[i] = 12'hF00;
        foreach (dmem[i]) dmem[i] = 8'(i * 7 + 3);
    endtask

    task automatic clear_model();
        i_ack = 1'b0; d_ack = 1'b0; i_rdata = '0; d_rdata = '0;
        sb.delete(); wq.delete();
        i_cnt = 0; d_cnt = 0;
        m_pc = '0; m_acc = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        foreach (dmem[i]) m_dmem[i] = dmem[i];
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        first_fetch = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        release_reset();
    endtask

    task automatic run_prog(input int max_cyc);
        int n = 0;
        int reqs = 0;
        int bad = 0;
        logic [7:0] pc_h, acc_h;
        while (halted !== 1'b1 && n < max_cyc) begin step(); n++; end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout got halted=%b want 1 after %0d cycles", halted, n);
        end
        pc_h = pc_out; acc_h = acc_out;
        for (int k = 0; k < 5; k++) begin
            step();
            if (i_req === 1'b1 || d_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || halted !== 1'b1 || pc_out !== pc_h || acc_out !== acc_h) begin
            errors++;
            $display("FAIL halt_frozen got reqs=%0d halted=%b pc=%h acc=%h want 0 1 %h %h",
                     reqs, halted, pc_out, acc_out, pc_h, acc_h);
        end
        checks++;
        if (sb.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL pending_items got sb=%0d wq=%0d want 0 0", sb.size(), wq.size());
        end
        foreach (dmem[i]) if (dmem[i] !== m_dmem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dmem_contents got %0d differing bytes want 0", bad);
        end
    endtask

    task automatic test_reset();
        stray = 1'b0; i_wait = 0; d_wait = 0;
        clear_mem();
        clear_model();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL rst_i_req got %b want 0", i_req); end
        checks++; if (d_req !== 1'b0) begin errors++; $display("FAIL rst_d_req got %b want 0", d_req); end
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL rst_pc got %h want 00", pc_out); end
        checks++; if (acc_out !== 8'h00) begin errors++; $display("FAIL rst_acc got %h want 00", acc_out); end
        checks++;
        if ({flag_z, flag_n, flag_c} !== 3'b000) begin
            errors++; $display("FAIL rst_flags got %b want 000", {flag_z, flag_n, flag_c});
        end
        checks++;
        if (halted !== 1'b0 || retire !== 1'b0) begin
            errors++; $display("FAIL rst_halt_retire got %b%b want 00", halted, retire);
        end
    endtask

    task automatic test_zero_wait();
        clear_mem();
        put(0, 4'h8, 8'h05); put(1, 4'h9, 8'h03); put(2, 4'h2, 8'h10); put(3, 4'hF, 8'h00);
        i_wait = 0; d_wait = 0; stray = 1'b0;
        do_reset();
        run_prog(100);
        checks++;
        if (acc_out !== 8'h08 || flag_z !== 1'b0 || pc_out !== 8'h03) begin
            errors++; $display("FAIL zw_final got acc=%h z=%b pc=%h want 08 0 03", acc_out, flag_z, pc_out);
        end
        checks++;
        if (dmem[16] !== 8'h08) begin
            errors++; $display("FAIL zw_store got %h want 08", dmem[16]);
        end
    endtask

    task automatic test_arith();
        clear_mem();
        dmem[8'h11] = 8'h01;
        put(0, 4'h8, 8'hFF); put(1, 4'h9, 8'h01); put(2, 4'h8, 8'h00); put(3, 4'h4, 8'h11);
        i_wait = 0; d_wait = 0; stray = 1'b0;
        do_reset();
        run_prog(100);
        checks++;
        if (acc_out !== 8'hFF || {flag_z, flag_n, flag_c} !== 3'b011) begin
            errors++; $display("FAIL arith_final got acc=%h znc=%b want ff 011", acc_out, {flag_z, flag_n, flag_c});
        end
    endtask

    task automatic test_wait_states();
        clear_mem();
        dmem[8'h12] = 8'hA5;
        put(0, 4'h1, 8'h12);
        i_wait = 3; d_wait = 2; stray = 1'b0;
        do_reset();
        run_prog(200);
        checks++;
        if (acc_out !== 8'hA5 || flag_n !== 1'b1) begin
            errors++; $display("FAIL wait_lda got acc=%h n=%b want a5 1", acc_out, flag_n);
        end
    endtask

    task automatic test_branches();
        clear_mem();
        put(8'h00, 4'hD, 8'h60); put(8'h01, 4'h8, 8'h00); put(8'h02, 4'hE, 8'h20);
        put(8'h20, 4'h8, 8'h01); put(8'h21, 4'hE, 8'h30); put(8'h22, 4'h8, 8'h40);
        put(8'h23, 4'hA, 8'h00); put(8'h24, 4'hD, 8'h40); put(8'h40, 4'hC, 8'hFF);
        put(8'hFF, 4'hE, 8'h30); put(8'h60, 4'hF, 8'h00);
        put(8'h30, 4'h8, 8'hEE); put(8'h03, 4'h8, 8'hEE);
        i_wait = 1; d_wait = 0; stray = 1'b0;
        do_reset();
        run_prog(200);
        checks++;
        if (pc_out !== 8'h60 || acc_out !== 8'h80 || {flag_z, flag_n, flag_c} !== 3'b010) begin
            errors++; $display("FAIL branch_final got pc=%h acc=%h znc=%b want 60 80 010",
                               pc_out, acc_out, {flag_z, flag_n, flag_c});
        end
    endtask

    task automatic test_logic_stray();
        clear_mem();
        dmem[8'h13] = 8'h20; dmem[8'h14] = 8'h1F; dmem[8'h15] = 8'h03; dmem[8'h16] = 8'h13;
        put(0, 4'h8, 8'hF0); put(1, 4'h3, 8'h13); put(2, 4'h5, 8'h14); put(3, 4'h6, 8'h15);
        put(4, 4'h7, 8'h16); put(5, 4'h2, 8'h17); put(6, 4'h8, 8'h02); put(7, 4'hB, 8'h00);
        i_wait = 0; d_wait = 1; stray = 1'b1;
        do_reset();
        run_prog(200);
        stray = 1'b0;
        checks++;
        if (acc_out !== 8'h01 || {flag_z, flag_n, flag_c} !== 3'b000 || dmem[8'h17] !== 8'h00) begin
            errors++; $display("FAIL logic_final got acc=%h znc=%b m17=%h want 01 000 00",
                               acc_out, {flag_z, flag_n, flag_c}, dmem[8'h17]);
        end
    endtask

    task automatic test_reset_mid_dmem();
        int n = 0;
        clear_mem();
        dmem[8'h30] = 8'h5A;
        put(0, 4'h8, 8'hFF); put(1, 4'h9, 8'h02); put(2, 4'h1, 8'h30);
        i_wait = 0; d_wait = 10; stray = 1'b0;
        do_reset();
        while (d_req !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (d_req !== 1'b1) begin
            errors++; $display("FAIL mid_dmem_reach got d_req=%b want 1", d_req);
        end
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (d_req !== 1'b0 || i_req !== 1'b0) begin
            errors++; $display("FAIL mid_rst_req got d_req=%b i_req=%b want 0 0", d_req, i_req);
        end
        checks++;
        if (pc_out !== 8'h00 || acc_out !== 8'h00 || {flag_z, flag_n, flag_c} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_state got pc=%h acc=%h znc=%b want 00 00 000",
                               pc_out, acc_out, {flag_z, flag_n, flag_c});
        end
        d_wait = 1;
        clear_model();
        release_reset();
        step();
        checks++;
        if (i_req !== 1'b1 || i_addr !== 8'h00) begin
            errors++; $display("FAIL mid_restart got i_req=%b i_addr=%h want 1 00", i_req, i_addr);
        end
        run_prog(200);
        checks++;
        if (acc_out !== 8'h5A || pc_out !== 8'h03) begin
            errors++; $display("FAIL mid_rerun got acc=%h pc=%h want 5a 03", acc_out, pc_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_ack = 1'b0; d_ack = 1'b0; i_rdata = '0; d_rdata = '0;
        stray = 1'b0; first_fetch = 1'b0;
        test_reset();
        test_zero_wait();
        test_arith();
        test_wait_states();
        test_branches();
        test_logic_stray();
        test_reset_mid_dmem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
